// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port general register file.
//
// Purpose:
//   Decode-stage register file with NUM_RD combinational read ports and
//   NUM_WR write ports. The storage array carries no reset; instead a
//   sequential clear engine walks every entry after reset and raises
//   'ready' once the whole array holds zero. Optional hardwired zero
//   register (ZERO_REG). When two write ports hit the same address on the
//   same edge, the higher port index wins and the lower write is dropped.
//
// Configuration macro:
//   REGFILE_MP_BYPASS_EN  defined   -> same-cycle write-to-read forwarding
//                         undefined -> reads reflect the array only
//
// Ports:
//   clk     in   rising-edge clock
//   resetn  in   asynchronous active-low reset
//   ready   out  high once the clear sequence has completed
//   raddr   in   NUM_RD*ADDR_W read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata   out  NUM_RD*DATA_W read data, port k at [k*DATA_W +: DATA_W]
//   we      in   NUM_WR per-port write enables
//   waddr   in   NUM_WR*ADDR_W write addresses, packed as raddr
//   wdata   in   NUM_WR*DATA_W write data, packed as rdata
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    output logic                     ready,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] count_reg, count_next;
    logic              ready_reg, ready_next;

    logic [DATA_W-1:0] mem [DEPTH];

    // Unpacked views of the write ports.
    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [DATA_W-1:0] wd [NUM_WR];
    logic [NUM_WR-1:0] wr_ok;   // port wants to write and the write is legal
    logic [NUM_WR-1:0] wr_eff;  // legal and not overridden by a higher port

    // ------------------------------------------------------------------
    // Control: state, clear counter and registered ready
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= INIT;
            count_reg <= '0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            ready_reg <= ready_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        ready_next = ready_reg;
        case (state_reg)
            INIT: begin
                if (count_reg == ADDR_W'(DEPTH - 1)) begin
                    // Last entry is cleared on this edge; the counter stays
                    // parked here for as long as we remain in RUN.
                    state_next = RUN;
                    ready_next = 1'b1;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign ready = ready_reg;

    // ------------------------------------------------------------------
    // Write-port qualification
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
        assign wa[gi]    = waddr[gi*ADDR_W +: ADDR_W];
        assign wd[gi]    = wdata[gi*DATA_W +: DATA_W];
        assign wr_ok[gi] = we[gi] && (state_reg == RUN) &&
                           !((ZERO_REG != 0) && (wa[gi] == '0));
    end

    // A lower-index write is dropped when any higher port writes the same
    // address on the same edge, so surviving writes never collide.
    always_comb begin
        wr_eff = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_eff[w] = wr_ok[w];
            for (int h = w + 1; h < NUM_WR; h++) begin
                if (wr_ok[h] && (wa[h] == wa[w])) begin
                    wr_eff[w] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array (no reset: cleared by the INIT walk instead)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_reg == INIT) begin
            mem[count_reg] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_eff[w]) begin
                    mem[wa[w]] <= wd[w];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[gi*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem[ra];
`ifdef REGFILE_MP_BYPASS_EN
            // Ascending scan: the highest matching write port is applied
            // last, matching the write-priority rule.
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w] && (wa[w] == ra)) begin
                    rd = wd[w];
                end
            end
`endif
            // Array content is undefined until the clear walk finishes.
            if ((state_reg != RUN) || ((ZERO_REG != 0) && (ra == '0))) begin
                rd = '0;
            end
        end

        assign rdata[gi*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- scoreboard bench for regfile_mp.
//
// Two instances share one clock:
//   inst 0: DATA_W=32, DEPTH=32, NUM_RD=2, NUM_WR=2, ZERO_REG=1
//   inst 1: DATA_W=64, DEPTH=16, NUM_RD=4, NUM_WR=1, ZERO_REG=1
// Stimulus drives one cycle at a time and pushes the expected ready/rdata
// for that cycle; a monitor pops and compares on the falling edge. The
// reference model is a plain array per instance plus a count of clock
// edges since reset release.
module tb_regfile_mp;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inst 0 signals
    logic         resetn_a, ready_a;
    logic [9:0]   raddr_a;
    logic [63:0]  rdata_a;
    logic [1:0]   we_a;
    logic [9:0]   waddr_a;
    logic [63:0]  wdata_a;

    // inst 1 signals
    logic         resetn_b, ready_b;
    logic [15:0]  raddr_b;
    logic [255:0] rdata_b;
    logic [0:0]   we_b;
    logic [3:0]   waddr_b;
    logic [63:0]  wdata_b;

    regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .resetn(resetn_a), .ready(ready_a),
        .raddr(raddr_a), .rdata(rdata_a),
        .we(we_a), .waddr(waddr_a), .wdata(wdata_a)
    );

    regfile_mp #(.DATA_W(64), .DEPTH(16), .NUM_RD(4), .NUM_WR(1), .ZERO_REG(1)) dut_b (
        .clk(clk), .resetn(resetn_b), .ready(ready_b),
        .raddr(raddr_b), .rdata(rdata_b),
        .we(we_b), .waddr(waddr_b), .wdata(wdata_b)
    );

    // ------------------------------------------------------------------
    // Scoreboard and counters
    // ------------------------------------------------------------------
    typedef struct {
        int           inst;
        int           id;
        logic         rdy;
        logic [255:0] d;
    } exp_t;

    exp_t q [$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   txn     = 0;

    function automatic void chk(string nm, int id, int lane, logic [63:0] act, logic [63:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s txn=%0d lane=%0d got=%h expected=%h", nm, id, lane, act, exp_v);
    endfunction

    // ------------------------------------------------------------------
    // Reference model: contents per instance, edges since reset release
    // ------------------------------------------------------------------
    logic [63:0] mdl [2][32];
    int          edges [2];

    always @(posedge clk) begin
        if (!resetn_a) begin
            edges[0] <= 0;
            for (int i = 0; i < 32; i++) mdl[0][i] <= '0;
        end else if (edges[0] < 32) begin
            edges[0] <= edges[0] + 1;
        end else begin
            // port 0 loses to port 1 on the same address; address 0 is read-only
            if (we_a[0] && waddr_a[4:0] != 0 && !(we_a[1] && waddr_a[9:5] == waddr_a[4:0]))
                mdl[0][waddr_a[4:0]] <= {32'h0, wdata_a[31:0]};
            if (we_a[1] && waddr_a[9:5] != 0)
                mdl[0][waddr_a[9:5]] <= {32'h0, wdata_a[63:32]};
        end

        if (!resetn_b) begin
            edges[1] <= 0;
            for (int i = 0; i < 32; i++) mdl[1][i] <= '0;
        end else if (edges[1] < 16) begin
            edges[1] <= edges[1] + 1;
        end else if (we_b[0] && waddr_b != 0) begin
            mdl[1][waddr_b] <= wdata_b;
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.inst == 0) begin
                chk("ready_a", e.id, 0, {63'h0, ready_a}, {63'h0, e.rdy});
                for (int k = 0; k < 2; k++)
                    chk("rdata_a", e.id, k, {32'h0, rdata_a[k*32 +: 32]}, e.d[k*64 +: 64]);
            end else begin
                chk("ready_b", e.id, 0, {63'h0, ready_b}, {63'h0, e.rdy});
                for (int k = 0; k < 4; k++)
                    chk("rdata_b", e.id, k, rdata_b[k*64 +: 64], e.d[k*64 +: 64]);
            end
            $display("txn %0d inst%0d ready_exp=%0b rd0_exp=%h", e.id, e.inst, e.rdy, e.d[63:0]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [19:0] ra4(int a0, int a1, int a2, int a3);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    function automatic logic [9:0] wa2(int a0, int a1);
        return {5'(a1), 5'(a0)};
    endfunction

    function automatic logic [127:0] wd2(logic [63:0] d0, logic [63:0] d1);
        return {d1, d0};
    endfunction

    // Drive one cycle on an instance and push what its outputs must show.
    task automatic cyc(input int inst, input logic [1:0] we_v, input logic [9:0] wa,
                       input logic [127:0] wd, input logic [19:0] ra);
        exp_t        e;
        int          dep, nrd, nwr, a, wa_w;
        logic        rst;
        logic [63:0] d, mask;
        @(posedge clk);
        #1;
        if (inst == 0) begin
            we_a    = we_v;
            waddr_a = wa;
            wdata_a = {wd[95:64], wd[31:0]};
            raddr_a = ra[9:0];
        end else begin
            we_b    = we_v[0];
            waddr_b = wa[3:0];
            wdata_b = wd[63:0];
            raddr_b = {ra[18:15], ra[13:10], ra[8:5], ra[3:0]};
        end
        dep  = (inst == 0) ? 32 : 16;
        nrd  = (inst == 0) ? 2 : 4;
        nwr  = (inst == 0) ? 2 : 1;
        rst  = (inst == 0) ? resetn_a : resetn_b;
        mask = (inst == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        e.inst = inst;
        e.id   = txn++;
        e.rdy  = rst && (edges[inst] >= dep);
        e.d    = '0;
        for (int k = 0; k < nrd; k++) begin
            a = int'(ra[k*5 +: 5]) % dep;
            d = mdl[inst][a];
`ifdef REGFILE_MP_BYPASS_EN
            for (int w = 0; w < nwr; w++) begin
                wa_w = int'(wa[w*5 +: 5]) % dep;
                if (we_v[w] && wa_w == a) d = wd[w*64 +: 64] & mask;
            end
`endif
            if (a == 0 || !e.rdy) d = '0;
            e.d[k*64 +: 64] = d;
        end
        q.push_back(e);
    endtask

    task automatic rand_cyc(input int inst, input int amax);
        cyc(inst, 2'($urandom_range(0, 3)),
            wa2($urandom_range(0, amax), $urandom_range(0, amax)),
            wd2({$urandom, $urandom}, {$urandom, $urandom}),
            ra4($urandom_range(0, amax), $urandom_range(0, amax),
                $urandom_range(0, amax), $urandom_range(0, amax)));
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        resetn_a = 1'b0; resetn_b = 1'b0;
        we_a = '0; waddr_a = '0; wdata_a = '0; raddr_a = '0;
        we_b = '0; waddr_b = '0; wdata_b = '0; raddr_b = '0;

        // Reset held three cycles with writes attempted.
        repeat (3) cyc(0, 2'b11, wa2(5, 6), wd2(64'h55, 64'h66), ra4(5, 6, 0, 0));
        @(posedge clk); #1;
        resetn_a = 1'b1; resetn_b = 1'b1;

        // INIT walk: writes to 5 are ignored; ready checked every cycle.
        for (int i = 0; i < 34; i++) begin
            if (i < 31) cyc(0, 2'b01, wa2(5, 0), wd2(64'h1234_5555, 64'h0), ra4(5, i % 32, 0, 0));
            else        cyc(0, 2'b00, wa2(0, 0), wd2(64'h0, 64'h0), ra4(5, i % 32, 0, 0));
        end

        // Every address reads zero after the clear.
        for (int a = 0; a < 32; a += 2)
            cyc(0, 2'b00, wa2(0, 0), wd2(64'h0, 64'h0), ra4(a, a + 1, 0, 0));

        // Basic write/read and zero register.
        cyc(0, 2'b01, wa2(7, 0), wd2(64'hDEADBEEF, 64'h0), ra4(7, 7, 0, 0));
        cyc(0, 2'b00, wa2(0, 0), wd2(64'h0, 64'h0), ra4(7, 7, 0, 0));
        cyc(0, 2'b01, wa2(0, 0), wd2(64'h12345678, 64'h0), ra4(0, 7, 0, 0));
        cyc(0, 2'b00, wa2(0, 0), wd2(64'h0, 64'h0), ra4(0, 0, 0, 0));

        // Dual-write conflict and distinct addresses.
        cyc(0, 2'b11, wa2(3, 3), wd2(64'h1111, 64'h2222), ra4(3, 4, 0, 0));
        cyc(0, 2'b11, wa2(4, 5), wd2(64'h4444, 64'h5555), ra4(3, 3, 0, 0));
        cyc(0, 2'b00, wa2(0, 0), wd2(64'h0, 64'h0), ra4(4, 5, 0, 0));

        // Same-cycle read of an address being written.
        cyc(0, 2'b01, wa2(9, 0), wd2(64'hCAFE, 64'h0), ra4(9, 9, 0, 0));
        cyc(0, 2'b00, wa2(0, 0), wd2(64'h0, 64'h0), ra4(9, 0, 0, 0));
        cyc(0, 2'b11, wa2(11, 11), wd2(64'hA1, 64'hB2), ra4(11, 11, 0, 0));

        // Random traffic on a narrow address range to provoke collisions.
        for (int i = 0; i < 300; i++) rand_cyc(0, 7);

        // Reset mid-run.
        cyc(0, 2'b01, wa2(10, 0), wd2(64'hAAAA, 64'h0), ra4(10, 10, 0, 0));
        cyc(0, 2'b00, wa2(0, 0), wd2(64'h0, 64'h0), ra4(10, 10, 0, 0));
        @(negedge clk); #2;
        resetn_a = 1'b0;
        #1;
        chk("async_ready_drop", -1, 0, {63'h0, ready_a}, 64'h0);
        repeat (3) cyc(0, 2'b01, wa2(10, 0), wd2(64'hBBBB, 64'h0), ra4(10, 0, 0, 0));
        @(posedge clk); #1;
        resetn_a = 1'b1;
        for (int i = 0; i < 34; i++)
            cyc(0, 2'b00, wa2(0, 0), wd2(64'h0, 64'h0), ra4(10, 7, 0, 0));

        // Wide/shallow instance: already out of INIT in the background.
        cyc(1, 2'b01, wa2(15, 0), wd2(64'hFFFF_FFFF_0000_0001, 64'h0), ra4(15, 15, 15, 15));
        cyc(1, 2'b00, wa2(0, 0), wd2(64'h0, 64'h0), ra4(15, 15, 15, 15));
        cyc(1, 2'b01, wa2(0, 0), wd2(64'h77, 64'h0), ra4(0, 15, 0, 15));
        for (int i = 0; i < 150; i++) rand_cyc(1, 15);

        // Restart inst 1 and watch ready return after 16 edges.
        @(posedge clk); #1;
        resetn_b = 1'b0;
        repeat (2) cyc(1, 2'b01, wa2(15, 0), wd2(64'h99, 64'h0), ra4(15, 1, 2, 3));
        @(posedge clk); #1;
        resetn_b = 1'b1;
        for (int i = 0; i < 18; i++)
            cyc(1, 2'b00, wa2(0, 0), wd2(64'h0, 64'h0), ra4(15, i % 16, 1, 2));

        // Let the monitor drain, then summarise.
        @(negedge clk); #1;
        chk("queue_drained", -1, 0, 64'(q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
